// File: rtl/reg_bank_scoreboard.sv
// reg_bank_scoreboard: 32 x BITS register bank with pending-write scoreboard for decode stalls.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback to reads and the scoreboard.
module reg_bank_scoreboard #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [BITS-1:0] rd1,
    output logic [BITS-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [BITS-1:0] wd,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            busy1,
    output logic            busy2,
    output logic            stall,
    output logic [5:0]      pending_count
);
    logic [BITS-1:0] regs [32];
    logic [31:0]     busy;
    logic [31:0]     clr_vec;
    logic [31:0]     set_vec;
    logic [31:0]     busy_eff;
    logic            wr_en;
    logic            inc;
    logic            dec;

    always_comb begin
        wr_en    = we && wa != 5'd0;
        clr_vec  = wr_en ? (32'd1 << wa) : 32'd0;
`ifdef REGFILE_BYPASS_EN
        busy_eff = busy & ~clr_vec;
        rd1      = (wr_en && wa == rs1) ? wd : regs[rs1];
        rd2      = (wr_en && wa == rs2) ? wd : regs[rs2];
`else
        busy_eff = busy;
        rd1      = regs[rs1];
        rd2      = regs[rs2];
`endif
        busy1    = busy_eff[rs1];
        busy2    = busy_eff[rs2];
        stall    = issue_valid && (busy1 || busy2 || busy_eff[issue_rd]);
        set_vec  = (issue_valid && !stall && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;
        // set wins over a same-edge clear, so a clear only counts when nothing re-sets that bit
        inc      = (|set_vec) && !busy[issue_rd];
        dec      = wr_en && busy[wa] && !set_vec[wa];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            busy          <= '0;
            pending_count <= '0;
        end else begin
            if (wr_en) regs[wa] <= wd;
            busy          <= (busy & ~clr_vec) | set_vec;
            pending_count <= pending_count + {5'd0, inc} - {5'd0, dec};
        end
    end
endmodule

// File: tb/tb_reg_bank_scoreboard.sv
// tb_reg_bank_scoreboard: directed and randomized checks of reg_bank_scoreboard against a behavioural model.
// Honours REGFILE_BYPASS_EN to select the expected forwarding behaviour.
module tb_reg_bank_scoreboard;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs1 = '0, rs2 = '0, wa = '0, issue_rd = '0;
    logic [63:0] rd1, rd2, wd = '0;
    logic        we = 1'b0, issue_valid = 1'b0;
    logic        busy1, busy2, stall;
    logic [5:0]  pending_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] mregs [32];
    logic [31:0] mbusy;
    logic [63:0] fill_data [32];
    bit          acc;

    reg_bank_scoreboard #(.BITS(64)) dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy1(busy1), .busy2(busy2), .stall(stall), .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    function automatic bit eff(input logic [4:0] r);
        return r != 5'd0 && mbusy[r] && !(BYP && we && wa == r);
    endfunction

    function automatic logic [63:0] exp_rd(input logic [4:0] r);
        if (r == 5'd0) return 64'd0;
        if (BYP && we && wa == r) return wd;
        return mregs[r];
    endfunction

    function automatic bit exp_stall();
        return issue_valid && (eff(rs1) || eff(rs2) || eff(issue_rd));
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // reference model: architectural state updated from the rules, not from the RTL structure
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = '0;
            mbusy = '0;
        end else begin
            acc = issue_valid && !exp_stall() && issue_rd != 5'd0;
            if (we && wa != 5'd0) begin
                mregs[wa] = wd;
                mbusy[wa] = 1'b0;
            end
            if (acc) mbusy[issue_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rd1", rd1, exp_rd(rs1));
            chk("rd2", rd2, exp_rd(rs2));
            chk("busy1", 64'(busy1), 64'(eff(rs1)));
            chk("busy2", 64'(busy2), 64'(eff(rs2)));
            chk("stall", 64'(stall), 64'(exp_stall()));
            chk("pending_count", 64'(pending_count), 64'(exp_count()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_rd1", rd1, 64'd0);
        chk("reset_pending", 64'(pending_count), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);

        // x0 protection
        we = 1'b1; wa = 5'd0; wd = '1; issue_valid = 1'b1; issue_rd = 5'd0;
        #1 chk("x0_rd1", rd1, 64'd0);
        tick();
        idle();
        #1 chk("x0_pending", 64'(pending_count), 64'd0);
        chk("x0_rd1_after", rd1, 64'd0);

        // asynchronous mid-cycle reset
        we = 1'b1; wa = 5'd5; wd = 64'hDEAD;
        tick();
        idle(); rs1 = 5'd5;
        #1 chk("x5_written", rd1, 64'hDEAD);
        #1 reset = 1'b1;
        #1 chk("async_reset_rd1", rd1, 64'd0);
        chk("async_reset_pending", 64'(pending_count), 64'd0);
        tick();
        reset = 1'b0;
        idle();

        // RAW
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1 chk("raw_issue_stall", 64'(stall), 64'd0);
        tick();
        #1 chk("raw_pending1", 64'(pending_count), 64'd1);
        issue_rd = 5'd0; rs1 = 5'd7;
        #1 chk("raw_stall", 64'(stall), 64'd1);
        chk("raw_busy1", 64'(busy1), 64'd1);
        we = 1'b1; wa = 5'd7; wd = 64'h1234;
        #1 chk("raw_wb_stall", 64'(stall), BYP ? 64'd0 : 64'd1);
        if (BYP) chk("raw_bypass_rd1", rd1, 64'h1234);
        tick();
        we = 1'b0;
        #1 chk("raw_after_stall", 64'(stall), 64'd0);
        chk("raw_after_rd1", rd1, 64'h1234);
        chk("raw_after_pending", 64'(pending_count), 64'd0);
        idle();

        // WAW
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        #1 chk("waw_stall", 64'(stall), 64'd1);
        tick();
        #1 chk("waw_pending", 64'(pending_count), 64'd1);
        issue_rd = 5'd3;
        #1 chk("waw_r3_accept", 64'(stall), 64'd0);
        tick();
        #1 chk("r3_pending", 64'(pending_count), 64'd2);

        // simultaneous writeback and re-issue of x3
        we = 1'b1; wa = 5'd3; wd = 64'hABC; issue_rd = 5'd3;
        #1 chk("setclr_stall", 64'(stall), BYP ? 64'd0 : 64'd1);
        tick();
        idle(); rs1 = 5'd3;
        #1 chk("setclr_busy1", 64'(busy1), BYP ? 64'd1 : 64'd0);
        chk("setclr_rd1", rd1, 64'hABC);
        chk("setclr_pending", 64'(pending_count), BYP ? 64'd2 : 64'd1);
        we = 1'b1; wa = 5'd3; wd = 64'hABD;
        tick();
        wa = 5'd9; wd = 64'h99;
        tick();
        idle();
        #1 chk("drain_pending", 64'(pending_count), 64'd0);

        // fill all 31 registers, then drain
        issue_valid = 1'b1;
        for (int r = 1; r < 32; r++) begin
            issue_rd = 5'(r);
            tick();
        end
        idle();
        #1 chk("fill_pending", 64'(pending_count), 64'd31);
        we = 1'b1;
        for (int r = 1; r < 32; r++) begin
            fill_data[r] = {$urandom, $urandom};
            wa = 5'(r); wd = fill_data[r];
            tick();
        end
        idle();
        #1 chk("empty_pending", 64'(pending_count), 64'd0);
        for (int r = 1; r < 32; r++) begin
            rs1 = 5'(r); rs2 = 5'(32 - r);
            #1 chk("fill_rd1", rd1, fill_data[r]);
            chk("fill_rd2", rd2, fill_data[32 - r]);
        end

        // randomized traffic, checked by the negedge compare process
        for (int i = 0; i < 3000; i++) begin
            tick();
            we = ($urandom_range(0, 1) == 1);
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
        end
        tick();
        idle();
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_bank_scoreboard.md
# reg_bank_scoreboard

Architectural integer register bank for the decode stage: 32 × BITS storage with two combinational read ports and one writeback port. It also keeps a per-register pending-write scoreboard, so decode can stall an instruction whose sources or destination still await writeback. Stored registers feed the decode read-select logic; writeback arrives from the final pipeline stage.

## Interface
- BITS, 64, register width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- rs1  input  5  read address, port 1
- rs2  input  5  read address, port 2
- rd1  output  BITS  register[rs1]
- rd2  output  BITS  register[rs2]
- we  input  1  writeback enable
- wa  input  5  writeback address
- wd  input  BITS  writeback data
- issue_valid  input  1  decode requests issue of an instruction writing issue_rd
- issue_rd  input  5  destination of issuing instruction (0 = no destination)
- busy1  output  1  rs1 has a pending write
- busy2  output  1  rs2 has a pending write
- stall  output  1  issue rejected this cycle
- pending_count  output  6  number of registers currently busy (0–31)

## Operation
- Storage: regs[0..31], busy[0..31]. Register x0 reads 0, ignores writes, never becomes busy.
- Writeback: on a clock edge with we=1 and wa≠0, regs[wa]←wd and busy[wa]←0. Writeback to a non-busy register is legal and does not change pending_count.
- clr_vec: one-hot of wa when we=1 and wa≠0, else 0.
- busy_eff: busy & ~clr_vec with the bypass feature, raw busy without it.
- busy1 = busy_eff[rs1]; busy2 = busy_eff[rs2]. Both are 0 for index 0.
- stall = issue_valid & (busy1 | busy2 | busy_eff[issue_rd]). This is a WAW/RAW check. Source use is not qualified, so decode drives rs1/rs2=0 for unused operands.
- Accepted issue (issue_valid=1, stall=0, issue_rd≠0): busy[issue_rd]←1 at the edge.
- Same edge, writeback clear and accepted-issue set to the same register: the set wins (busy stays 1) and the data is written.
- pending_count: +1 per accepted issue setting a bit, −1 per writeback clearing a set bit, net 0 when both occur. It always equals the popcount of busy.
- Reads are purely combinational from the stored array, with the optional bypass described under Configuration.

## Timing
- Reset (asynchronous assert, released synchronously by the environment):
  - regs all 0, busy all 0, pending_count=0.
  - Consequently rd1=rd2=0 and busy1=busy2=stall=0.
- Reset asserted mid-operation clears all state immediately, independent of clk. Writebacks and issues in that cycle are lost.
- Read latency is 0 cycles (combinational).
- Write and scoreboard updates take effect on the edge; they are visible the next cycle.
- stall is combinational from the current-cycle inputs, with no registered delay. Decode holds the instruction while stall=1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - rdN = wd when we=1, wa=rsN, rsN≠0; otherwise regs[rsN].
  - busy_eff excludes the register being written back this cycle, so the same-cycle writeback resolves RAW/WAW without a stall.
- Not defined:
  - rdN = regs[rsN] only.
  - busy_eff = busy, so an instruction depending on the register being written back stalls exactly one extra cycle.

## Test plan
- Reset: assert reset asynchronously mid-cycle after writing x5=0xDEAD → rd1(rs1=5)=0, pending_count=0, immediately without a clock edge.
- x0 protection: we=1, wa=0, wd=0xFFFF_FFFF_FFFF_FFFF; issue_rd=0 → rd1(rs1=0)=0, busy unchanged, pending_count=0.
- RAW stall:
  - Issue issue_rd=7 (accepted), pending_count=1.
  - Next cycle: issue with rs1=7 → stall=1, busy1=1.
  - Writeback wa=7, wd=0x1234 → with macro: same cycle stall=0, rd1=0x1234; without macro: stall=1 that cycle, next cycle stall=0, rd1=0x1234.
- WAW: busy[9]=1, issue issue_rd=9, rs1=rs2=0 → stall=1, pending_count stays 1.
- Simultaneous set/clear (macro defined): busy[3]=1, writeback wa=3 plus accepted issue issue_rd=3 same edge → busy[3]=1 after edge, regs[3]=wd, pending_count unchanged.
- Fill: issue rd=1..31 on consecutive cycles → pending_count reaches 31. Writeback all 31 → pending_count returns to 0, and every readback matches the written data.
